bomb_scheduler: RTL and testbench



---
 rtl/bomb_scheduler_if.sv | 30 +++
 rtl/bomb_scheduler.sv | 260 ++++++++++++++++++++++++++
 tb/tb_bomb_scheduler.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bomb_scheduler_if.sv
// Request / map-write bundle between the player logic, the bomb scheduler
// and the tile map. The scheduler sits on the slave modport; the
// requesting side and the tile map together form the master side.
interface bomb_scheduler_if;
  logic       tick;
  logic       reqA;
  logic [3:0] posAh;
  logic [3:0] posAv;
  logic       reqB;
  logic [3:0] posBh;
  logic [3:0] posBv;
  logic       grantA;
  logic       grantB;
  logic       wr_valid;
  logic       wr_ready;
  logic [3:0] wr_h;
  logic [3:0] wr_v;
  logic [3:0] wr_code;
  logic [3:0] live_cnt;

  modport master (
    output tick, reqA, posAh, posAv, reqB, posBh, posBv, wr_ready,
    input  grantA, grantB, wr_valid, wr_h, wr_v, wr_code, live_cnt
  );

  modport slave (
    input  tick, reqA, posAh, posAv, reqB, posBh, posBv, wr_ready,
    output grantA, grantB, wr_valid, wr_h, wr_v, wr_code, live_cnt
  );
endinterface

// File: rtl/bomb_scheduler.sv
// Bomb scheduler: round-robin placement of player A/B bombs into a slot
// table, per-slot fuse/blast timers on a shared tick, and a write
// sequencer that paints KILL / WALKOK onto the centre tile and its four
// in-range neighbours.
// Optional feature macro: BOMB_CHAIN_EN -- a completed KILL beat landing on
// another fused bomb detonates that bomb as soon as the sequencer is free.
module bomb_scheduler #(
  parameter int SLOTS       = 4,
  parameter int FUSE_TICKS  = 3,
  parameter int BLAST_TICKS = 2,
  parameter int HMAXTILE    = 9,
  parameter int VMAXTILE    = 5
) (
  input  logic            clk,
  input  logic            rst,
  bomb_scheduler_if.slave bus_if
);
  localparam int         IW          = (SLOTS > 1) ? $clog2(SLOTS) : 1;
  localparam logic [3:0] HMAX        = 4'(HMAXTILE);
  localparam logic [3:0] VMAX        = 4'(VMAXTILE);
  localparam logic [3:0] CODE_KILL   = 4'd3;
  localparam logic [3:0] CODE_WALKOK = 4'd14;

  typedef enum logic [1:0] {SLOT_FREE, SLOT_FUSE, SLOT_BLAST} slot_e;
  typedef enum logic [1:0] {SEQ_IDLE, SEQ_ARM, SEQ_CLR} seq_e;

  // Cross-slot views gathered from the per-slot generate blocks
  logic [SLOTS-1:0]      busy_vec, free_vec, match_a_vec, match_b_vec;
  logic [SLOTS-1:0]      pend_vec, pexp_vec, busy_d_vec;
  logic [SLOTS-1:0][3:0] h_all, v_all;

  // Arbitration
  logic          in_range_a, in_range_b, elig_a, elig_b, win_a, win_b, accept;
  logic [IW-1:0] alloc_idx;
  logic [3:0]    alloc_h, alloc_v;
  logic          ptr_q;                 // 0: A has priority, 1: B has priority
  logic          grant_a_q, grant_b_q;
  logic [3:0]    live_q, live_d;

  // Write sequencer
  seq_e          seq_q;
  logic [IW-1:0] sel_q;
  logic [2:0]    beat_q;                // 0 centre, 1 up, 2 down, 3 left, 4 right
  logic [3:0]    hc_q, vc_q;
  logic          wr_valid_q;
  logic [3:0]    wr_h_q, wr_v_q, wr_code_q;
  logic          hs, arm_hs, arm_done, clr_done;
  logic [4:0]    beat_ok;
  logic          nxt_found;
  logic [2:0]    nxt_beat;
  logic [3:0]    nxt_h, nxt_v;
  logic          pend_any;
  logic [IW-1:0] pend_idx;

  assign in_range_a = (bus_if.posAh <= HMAX) && (bus_if.posAv <= VMAX);
  assign in_range_b = (bus_if.posBh <= HMAX) && (bus_if.posBv <= VMAX);
  assign elig_a     = bus_if.reqA && in_range_a && (|free_vec) && !(|match_a_vec);
  assign elig_b     = bus_if.reqB && in_range_b && (|free_vec) && !(|match_b_vec);
  assign win_a      = elig_a && (!elig_b || !ptr_q);
  assign win_b      = elig_b && (!elig_a || ptr_q);
  assign accept     = win_a || win_b;
  assign alloc_h    = win_a ? bus_if.posAh : bus_if.posBh;
  assign alloc_v    = win_a ? bus_if.posAv : bus_if.posBv;

  assign hs       = wr_valid_q && bus_if.wr_ready;
  assign arm_hs   = hs && (seq_q == SEQ_ARM);
  assign arm_done = arm_hs && !nxt_found;
  assign clr_done = hs && (seq_q == SEQ_CLR) && !nxt_found;
  assign pend_any = |pend_vec;

  // Lowest-index free slot and lowest-index pending slot
  always_comb begin
    alloc_idx = '0;
    pend_idx  = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (free_vec[i]) alloc_idx = IW'(i);
      if (pend_vec[i]) pend_idx  = IW'(i);
    end
  end

  // Next in-range beat after the current one; out-of-range tiles are skipped
  always_comb begin
    beat_ok[0] = 1'b1;
    beat_ok[1] = (vc_q != 4'd0);
    beat_ok[2] = (vc_q < VMAX);
    beat_ok[3] = (hc_q != 4'd0);
    beat_ok[4] = (hc_q < HMAX);
    nxt_found  = 1'b0;
    nxt_beat   = 3'd0;
    for (int k = 4; k >= 1; k--) begin
      if (beat_ok[k] && (3'(k) > beat_q)) begin
        nxt_found = 1'b1;
        nxt_beat  = 3'(k);
      end
    end
    nxt_h = hc_q;
    nxt_v = vc_q;
    case (nxt_beat)
      3'd1:    nxt_v = vc_q - 4'd1;
      3'd2:    nxt_v = vc_q + 4'd1;
      3'd3:    nxt_h = hc_q - 4'd1;
      3'd4:    nxt_h = hc_q + 4'd1;
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    slot_e      state_q, state_d;
    logic [3:0] h_q, h_d, v_q, v_d, cnt_q, cnt_d;
    logic       pexp_q, pexp_d, pclr_q, pclr_d;
    logic       is_sel, is_alloc;

    assign is_sel   = (sel_q == IW'(gi));
    assign is_alloc = accept && (alloc_idx == IW'(gi));

    // Slot next state: timer, optional chain hit, sequencer completion, then allocation
    always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      cnt_d   = cnt_q;
      pexp_d  = pexp_q;
      pclr_d  = pclr_q;
      if (bus_if.tick && (state_q != SLOT_FREE) && (cnt_q != 4'd0)) begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          if (state_q == SLOT_FUSE) pexp_d = 1'b1;
          else                      pclr_d = 1'b1;
        end
      end
`ifdef BOMB_CHAIN_EN
      if (arm_hs && !is_sel && (state_q == SLOT_FUSE) &&
          (h_q == wr_h_q) && (v_q == wr_v_q)) begin
        cnt_d  = 4'd0;
        pexp_d = 1'b1;
      end
`endif
      if (arm_done && is_sel) begin
        state_d = SLOT_BLAST;
        cnt_d   = 4'(BLAST_TICKS);
        pexp_d  = 1'b0;
      end
      if (clr_done && is_sel) begin
        state_d = SLOT_FREE;
        cnt_d   = 4'd0;
        pclr_d  = 1'b0;
      end
      if (is_alloc) begin
        state_d = SLOT_FUSE;
        h_d     = alloc_h;
        v_d     = alloc_v;
        cnt_d   = 4'(FUSE_TICKS);
        pexp_d  = 1'b0;
        pclr_d  = 1'b0;
      end
    end

    // Slot registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= SLOT_FREE;
        h_q     <= 4'd0;
        v_q     <= 4'd0;
        cnt_q   <= 4'd0;
        pexp_q  <= 1'b0;
        pclr_q  <= 1'b0;
      end else begin
        state_q <= state_d;
        h_q     <= h_d;
        v_q     <= v_d;
        cnt_q   <= cnt_d;
        pexp_q  <= pexp_d;
        pclr_q  <= pclr_d;
      end
    end

    assign busy_vec[gi]    = (state_q != SLOT_FREE);
    assign free_vec[gi]    = (state_q == SLOT_FREE);
    assign busy_d_vec[gi]  = (state_d != SLOT_FREE);
    assign match_a_vec[gi] = busy_vec[gi] && (h_q == bus_if.posAh) && (v_q == bus_if.posAv);
    assign match_b_vec[gi] = busy_vec[gi] && (h_q == bus_if.posBh) && (v_q == bus_if.posBv);
    assign pend_vec[gi]    = pexp_q || pclr_q;
    assign pexp_vec[gi]    = pexp_q;
    assign h_all[gi]       = h_q;
    assign v_all[gi]       = v_q;
  end

  // Live count of the slots as they will be after this edge
  always_comb begin
    live_d = 4'd0;
    for (int i = 0; i < SLOTS; i++) live_d = live_d + {3'd0, busy_d_vec[i]};
  end

  // Round-robin pointer, grant pulses and live count
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q     <= 1'b0;
      grant_a_q <= 1'b0;
      grant_b_q <= 1'b0;
      live_q    <= 4'd0;
    end else begin
      if (elig_a && elig_b) ptr_q <= ~ptr_q;
      grant_a_q <= win_a;
      grant_b_q <= win_b;
      live_q    <= live_d;
    end
  end

  // Sequencer FSM: pick a pending slot, then stream its beats to the map
  always_ff @(posedge clk) begin
    if (rst) begin
      seq_q      <= SEQ_IDLE;
      sel_q      <= '0;
      beat_q     <= 3'd0;
      hc_q       <= 4'd0;
      vc_q       <= 4'd0;
      wr_valid_q <= 1'b0;
      wr_h_q     <= 4'd0;
      wr_v_q     <= 4'd0;
      wr_code_q  <= 4'd0;
    end else begin
      case (seq_q)
        SEQ_IDLE: begin
          if (pend_any) begin
            sel_q      <= pend_idx;
            hc_q       <= h_all[pend_idx];
            vc_q       <= v_all[pend_idx];
            beat_q     <= 3'd0;
            wr_valid_q <= 1'b1;
            wr_h_q     <= h_all[pend_idx];
            wr_v_q     <= v_all[pend_idx];
            wr_code_q  <= pexp_vec[pend_idx] ? CODE_KILL : CODE_WALKOK;
            seq_q      <= pexp_vec[pend_idx] ? SEQ_ARM : SEQ_CLR;
          end
        end
        SEQ_ARM, SEQ_CLR: begin
          if (hs) begin
            if (nxt_found) begin
              beat_q <= nxt_beat;
              wr_h_q <= nxt_h;
              wr_v_q <= nxt_v;
            end else begin
              wr_valid_q <= 1'b0;
              seq_q      <= SEQ_IDLE;
            end
          end
        end
        default: seq_q <= SEQ_IDLE;
      endcase
    end
  end

  assign bus_if.grantA   = grant_a_q;
  assign bus_if.grantB   = grant_b_q;
  assign bus_if.wr_valid = wr_valid_q;
  assign bus_if.wr_h     = wr_h_q;
  assign bus_if.wr_v     = wr_v_q;
  assign bus_if.wr_code  = wr_code_q;
  assign bus_if.live_cnt = live_q;
endmodule

// File: tb/tb_bomb_scheduler.sv
// Bench for bomb_scheduler: directed scenarios followed by random traffic,
// every cycle compared against a slot-list / beat-queue reference model.
module tb_bomb_scheduler;
  localparam int SLOTS = 4, FUSE_TICKS = 3, BLAST_TICKS = 2, HMAX = 9, VMAX = 5;

  logic clk, rst;
  bomb_scheduler_if bus();

  bomb_scheduler #(
    .SLOTS(SLOTS), .FUSE_TICKS(FUSE_TICKS), .BLAST_TICKS(BLAST_TICKS),
    .HMAXTILE(HMAX), .VMAXTILE(VMAX)
  ) dut (
    .clk(clk), .rst(rst), .bus_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks, n_pass;

  // Reference model: a bomb list plus the job being painted as a tile queue
  typedef struct { int st; int h; int v; int cnt; bit pend; } mslot_t; // st: 0 free, 1 fuse, 2 blast
  mslot_t ms [SLOTS];
  int     m_ptr;
  bit     m_ga, m_gb;
  bit     job_act, job_arm;
  int     job_slot;
  int     job_h [$];
  int     job_v [$];

  logic [11:0] obs [$];
  logic [11:0] expq [$];

  task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
    n_checks++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
  endtask

  function automatic logic [11:0] mk(input int h, input int v, input int c);
    return {4'(h), 4'(v), 4'(c)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < SLOTS; i++) ms[i] = '{0, 0, 0, 0, 1'b0};
    m_ptr = 0; m_ga = 0; m_gb = 0; job_act = 0; job_arm = 0; job_slot = 0;
    job_h.delete(); job_v.delete();
  endtask

  task automatic model_step(input bit tk, input bit ra, input int ah, input int av,
                            input bit rb, input int bh, input int bv, input bit rdy);
    mslot_t pre [SLOTS];
    bit hs, ea, eb, wa, wb, has_free, occ_a, occ_b;
    int sel, fr;
    pre = ms;
    hs  = job_act && rdy;
    if (tk)
      for (int i = 0; i < SLOTS; i++)
        if (ms[i].st != 0 && ms[i].cnt > 0) begin
          ms[i].cnt--;
          if (ms[i].cnt == 0) ms[i].pend = 1;
        end
`ifdef BOMB_CHAIN_EN
    if (hs && job_arm)
      for (int i = 0; i < SLOTS; i++)
        if (i != job_slot && pre[i].st == 1 && pre[i].h == job_h[0] && pre[i].v == job_v[0]) begin
          ms[i].cnt = 0; ms[i].pend = 1;
        end
`endif
    if (job_act) begin
      if (hs) begin
        void'(job_h.pop_front()); void'(job_v.pop_front());
        if (job_h.size() == 0) begin
          if (job_arm) begin ms[job_slot].st = 2; ms[job_slot].cnt = BLAST_TICKS; end
          else         begin ms[job_slot].st = 0; ms[job_slot].cnt = 0; end
          ms[job_slot].pend = 0;
          job_act = 0;
        end
      end
    end else begin
      sel = -1;
      for (int i = 0; i < SLOTS; i++) if (sel < 0 && pre[i].st != 0 && pre[i].pend) sel = i;
      if (sel >= 0) begin
        int h, v;
        h = pre[sel].h; v = pre[sel].v;
        job_act = 1; job_slot = sel; job_arm = (pre[sel].st == 1);
        job_h.push_back(h); job_v.push_back(v);
        if (v > 0)    begin job_h.push_back(h);     job_v.push_back(v - 1); end
        if (v < VMAX) begin job_h.push_back(h);     job_v.push_back(v + 1); end
        if (h > 0)    begin job_h.push_back(h - 1); job_v.push_back(v);     end
        if (h < HMAX) begin job_h.push_back(h + 1); job_v.push_back(v);     end
      end
    end
    has_free = 0; occ_a = 0; occ_b = 0; fr = -1;
    for (int i = 0; i < SLOTS; i++) begin
      if (pre[i].st == 0) begin has_free = 1; if (fr < 0) fr = i; end
      else begin
        if (pre[i].h == ah && pre[i].v == av) occ_a = 1;
        if (pre[i].h == bh && pre[i].v == bv) occ_b = 1;
      end
    end
    ea = ra && ah <= HMAX && av <= VMAX && has_free && !occ_a;
    eb = rb && bh <= HMAX && bv <= VMAX && has_free && !occ_b;
    wa = ea && (!eb || m_ptr == 0);
    wb = eb && (!ea || m_ptr == 1);
    if (ea && eb) m_ptr = 1 - m_ptr;
    if (wa) ms[fr] = '{1, ah, av, FUSE_TICKS, 1'b0};
    if (wb) ms[fr] = '{1, bh, bv, FUSE_TICKS, 1'b0};
    m_ga = wa; m_gb = wb;
  endtask

  task automatic compare_all();
    int live;
    live = 0;
    for (int i = 0; i < SLOTS; i++) if (ms[i].st != 0) live++;
    chk("grantA", 16'(bus.grantA), 16'(m_ga));
    chk("grantB", 16'(bus.grantB), 16'(m_gb));
    chk("live_cnt", 16'(bus.live_cnt), 16'(live));
    chk("wr_valid", 16'(bus.wr_valid), 16'(job_act));
    if (job_act) begin
      chk("wr_h", 16'(bus.wr_h), 16'(job_h[0]));
      chk("wr_v", 16'(bus.wr_v), 16'(job_v[0]));
      chk("wr_code", 16'(bus.wr_code), job_arm ? 16'd3 : 16'd14);
    end
  endtask

  // One clock: drive at the falling edge, sample 1 ns after the rising edge
  task automatic cycle(input bit tk, input bit ra, input int ah, input int av,
                       input bit rb, input int bh, input int bv, input bit rdy);
    bus.tick = tk; bus.reqA = ra; bus.posAh = 4'(ah); bus.posAv = 4'(av);
    bus.reqB = rb; bus.posBh = 4'(bh); bus.posBv = 4'(bv); bus.wr_ready = rdy;
    #1;
    if (bus.wr_valid && rdy) obs.push_back({bus.wr_h, bus.wr_v, bus.wr_code});
    model_step(tk, ra, ah, av, rb, bh, bv, rdy);
    @(posedge clk); #1;
    compare_all();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic tk();
    cycle(1, 0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    rst = 1; bus.tick = 0; bus.reqA = 0; bus.reqB = 0; bus.wr_ready = 1;
    bus.posAh = 0; bus.posAv = 0; bus.posBh = 0; bus.posBv = 0;
    @(posedge clk); #1;
    model_reset();
    compare_all();
    chk("rst_wr_h", 16'(bus.wr_h), 16'd0);
    chk("rst_wr_v", 16'(bus.wr_v), 16'd0);
    chk("rst_wr_code", 16'(bus.wr_code), 16'd0);
    @(negedge clk);
    rst = 0;
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (bus.wr_valid !== 1'b1 && k < 12) begin idle(1); k++; end
    chk(tag, 16'(bus.wr_valid), 16'd1);
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, 16'(obs.size()), 16'(expq.size()));
    for (int i = 0; i < expq.size(); i++)
      chk(tag, (i < obs.size()) ? 16'(obs[i]) : 16'hFFFF, 16'(expq[i]));
    obs.delete(); expq.delete();
  endtask

  initial begin
    logic [3:0] hold_h, hold_v, hold_c;
    n_checks = 0; n_pass = 0;
    rst = 1;
    @(negedge clk);
    do_reset();

    // Single bomb at (2,3): grant, explosion, clear
    cycle(0, 1, 2, 3, 0, 0, 0, 1);
    chk("grantA_23", 16'(bus.grantA), 16'd1);
    chk("live_23", 16'(bus.live_cnt), 16'd1);
    idle(1);
    repeat (3) begin tk(); idle(1); end
    idle(10);
    expq = '{mk(2,3,3), mk(2,2,3), mk(2,4,3), mk(1,3,3), mk(3,3,3)};
    check_beats("arm_23");
    repeat (2) begin tk(); idle(1); end
    idle(10);
    expq = '{mk(2,3,14), mk(2,2,14), mk(2,4,14), mk(1,3,14), mk(3,3,14)};
    check_beats("clr_23");
    chk("live_after_clr", 16'(bus.live_cnt), 16'd0);

    // Corner tiles clip their neighbour set
    cycle(0, 0, 0, 0, 1, 0, 0, 1);
    chk("grantB_00", 16'(bus.grantB), 16'd1);
    cycle(0, 1, 9, 5, 0, 0, 0, 1);
    chk("grantA_95", 16'(bus.grantA), 16'd1);
    repeat (3) tk();
    idle(12);
    expq = '{mk(0,0,3), mk(0,1,3), mk(1,0,3), mk(9,5,3), mk(9,4,3), mk(8,5,3)};
    check_beats("arm_corner");
    repeat (2) tk();
    idle(12);
    obs.delete();

    // Round-robin arbitration and duplicate rejection
    cycle(0, 1, 1, 1, 1, 4, 4, 1);
    chk("rr1_grantA", 16'(bus.grantA), 16'd1);
    chk("rr1_grantB", 16'(bus.grantB), 16'd0);
    cycle(0, 1, 2, 2, 1, 4, 4, 1);
    chk("rr2_grantA", 16'(bus.grantA), 16'd0);
    chk("rr2_grantB", 16'(bus.grantB), 16'd1);
    chk("rr_live", 16'(bus.live_cnt), 16'd2);
    cycle(0, 1, 1, 1, 0, 0, 0, 1);
    chk("dup_grantA", 16'(bus.grantA), 16'd0);

    // Fill the table; a fifth request is refused
    cycle(0, 1, 5, 1, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1, 6, 2, 1);
    chk("full_live", 16'(bus.live_cnt), 16'd4);
    cycle(0, 1, 7, 3, 0, 0, 0, 1);
    chk("full_grantA", 16'(bus.grantA), 16'd0);
    chk("full_live2", 16'(bus.live_cnt), 16'd4);

    // Back-pressure in the middle of an explosion
    obs.delete();
    repeat (3) tk();
    wait_valid("bp_wait");
    cycle(0, 0, 0, 0, 0, 0, 0, 1);
    hold_h = bus.wr_h; hold_v = bus.wr_v; hold_c = bus.wr_code;
    repeat (3) begin
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      chk("bp_valid", 16'(bus.wr_valid), 16'd1);
      chk("bp_hold", {4'd0, bus.wr_h, bus.wr_v, bus.wr_code}, {4'd0, hold_h, hold_v, hold_c});
    end
    idle(40);
    chk("bp_beats", 16'(obs.size()), 16'd20);
    repeat (2) tk();
    idle(40);
    chk("bp_live_end", 16'(bus.live_cnt), 16'd0);
    obs.delete();

    // Reset after the second KILL beat, then normal operation
    cycle(0, 1, 4, 2, 0, 0, 0, 1);
    repeat (3) tk();
    wait_valid("rst_wait");
    idle(2);
    do_reset();
    chk("rst_valid", 16'(bus.wr_valid), 16'd0);
    chk("rst_live", 16'(bus.live_cnt), 16'd0);
    cycle(0, 1, 4, 2, 0, 0, 0, 1);
    chk("post_rst_grantA", 16'(bus.grantA), 16'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++)
      cycle(($urandom_range(5, 0) == 0), ($urandom_range(2, 0) == 0),
            int'($urandom_range(10, 0)), int'($urandom_range(6, 0)),
            ($urandom_range(2, 0) == 0),
            int'($urandom_range(10, 0)), int'($urandom_range(6, 0)),
            ($urandom_range(3, 0) != 0));
    obs.delete();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
